// File: rtl/racer_pkg.sv
// Geometry shared by the rival-traffic engine and the sprite renderer, plus
// the LFSR-to-road-X scaling helper.
package racer_pkg;

  localparam int CAR_W      = 14;
  localparam int CAR_H      = 16;
  localparam int BG_X0      = 200;
  localparam int BG_Y0      = 150;
  localparam int BG_H       = 240;
  localparam int ROAD_MIN_X = 44;
  localparam int ROAD_SPAN  = 60;

  // Maps an 8-bit random value onto [0, span) with a 16-bit product.
  function automatic logic [15:0] scale_x(input logic [7:0] r, input logic [15:0] span);
    logic [15:0] prod;
    prod = {8'd0, r} * span;
    return prod >> 8;
  endfunction

endpackage

// File: rtl/lfsr_8bit.sv
// 8-bit Fibonacci LFSR, taps 7^5^4^3 shifted into the LSB; steps when enable=1.
module lfsr_8bit #(
  parameter logic [7:0] SEED = 8'hB5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      value <= SEED;
    else if (enable)
      value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
  end

endmodule

// File: rtl/rival_traffic_ctrl.sv
// Rival-car slot engine: LFSR spawning, frame-paced descent, despawn scoring,
// difficulty ramp and sticky player collision.
module rival_traffic_ctrl
  import racer_pkg::scale_x;
#(
  parameter int         NUM_RIVALS      = 3,
  parameter int         POS_W           = 10,
  parameter int         BG_X0           = racer_pkg::BG_X0,
  parameter int         BG_Y0           = racer_pkg::BG_Y0,
  parameter int         BG_H            = racer_pkg::BG_H,
  parameter int         ROAD_MIN_X      = racer_pkg::ROAD_MIN_X,
  parameter int         ROAD_SPAN       = racer_pkg::ROAD_SPAN,
  parameter int         CAR_W           = racer_pkg::CAR_W,
  parameter int         CAR_H           = racer_pkg::CAR_H,
  parameter int         STEP_FRAMES     = 15,
  parameter int         MIN_STEP_FRAMES = 3,
  parameter int         LEVEL_SCORE     = 8,
  parameter int         Y_STEP          = 2,
  parameter int         SPAWN_GAP       = 20,
  parameter logic [7:0] LFSR_SEED       = 8'hB5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_end,
  input  logic                          run,
  input  logic [POS_W-1:0]              player_x,
  input  logic [POS_W-1:0]              player_y,
  output logic [NUM_RIVALS*POS_W-1:0]   rival_x,
  output logic [NUM_RIVALS*POS_W-1:0]   rival_y,
  output logic [NUM_RIVALS-1:0]         rival_active,
  output logic                          collision,
  output logic [2:0]                    collide_idx,
  output logic [15:0]                   score,
  output logic [3:0]                    level
);

  localparam int                PW1       = POS_W + 1;
  localparam int                FC_W      = $clog2(STEP_FRAMES + 1);
  localparam int                SC_W      = $clog2(SPAWN_GAP + 2);
  localparam logic [SC_W-1:0]   GAP_V     = SC_W'(SPAWN_GAP);
  localparam logic [15:0]       LS_V      = 16'(LEVEL_SCORE);
  localparam logic [POS_W-1:0]  DESPAWN_Y = POS_W'(BG_Y0 + BG_H);
  localparam logic [POS_W-1:0]  SPAWN_Y   = POS_W'(BG_Y0);
  localparam logic [POS_W-1:0]  Y_STEP_V  = POS_W'(Y_STEP);
  localparam logic [PW1-1:0]    CW        = PW1'(CAR_W);
  localparam logic [PW1-1:0]    CH        = PW1'(CAR_H);

  logic [7:0]            lfsr;
  logic [FC_W-1:0]       frame_cnt;
  logic [FC_W-1:0]       period;
  logic [SC_W-1:0]       spawn_cnt;
  logic                  tick;
  logic                  spawn_now;
  logic [POS_W-1:0]      spawn_x;
  logic [NUM_RIVALS-1:0] overlap;
  logic [NUM_RIVALS-1:0] despawn;
  logic                  free_found;
  logic [2:0]            free_idx;
  logic                  hit;
  logic [2:0]            hit_idx;
  logic [3:0]            n_clear;
  logic [16:0]           score_sum;
  logic [15:0]           score_next;
  logic [15:0]           lvl_delta;
  logic [3:0]            level_next;
  logic [PW1-1:0]        px;
  logic [PW1-1:0]        py;

  lfsr_8bit #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .enable (frame_end),
    .value  (lfsr)
  );

  assign px      = {1'b0, player_x};
  assign py      = {1'b0, player_y};
  assign spawn_x = POS_W'(16'(BG_X0 + ROAD_MIN_X) + scale_x(lfsr, 16'(ROAD_SPAN)));

  always_comb begin
    if (STEP_FRAMES - int'(level) <= MIN_STEP_FRAMES)
      period = FC_W'(MIN_STEP_FRAMES);
    else
      period = FC_W'(STEP_FRAMES - int'(level));
  end

  assign tick      = frame_end && run && !collision && (frame_cnt >= period - FC_W'(1));
  assign spawn_now = tick && (spawn_cnt >= GAP_V) && free_found;

  // Priority encoders resolve to the lowest index by scanning downwards.
  always_comb begin
    free_found = 1'b0;
    free_idx   = 3'd0;
    hit        = 1'b0;
    hit_idx    = 3'd0;
    n_clear    = 4'd0;
    for (int i = NUM_RIVALS - 1; i >= 0; i--) begin
      if (!rival_active[i]) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
      if (overlap[i]) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
      n_clear = n_clear + 4'(despawn[i]);
    end
  end

  always_comb begin
    score_sum  = {1'b0, score} + 17'(n_clear);
    score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    lvl_delta  = (score_next / LS_V) - (score / LS_V);
    level_next = (lvl_delta >= 16'(4'd15 - level)) ? 4'd15 : level + lvl_delta[3:0];
  end

  for (genvar g = 0; g < NUM_RIVALS; g++) begin : g_slot
    logic [POS_W-1:0] x_q;
    logic [POS_W-1:0] y_q;
    logic             act_q;
    logic [PW1-1:0]   rx;
    logic [PW1-1:0]   ry;

    assign rx = {1'b0, x_q};
    assign ry = {1'b0, y_q};
    assign overlap[g] = act_q && (px < rx + CW) && (px + CW > rx) &&
                        (py < ry + CH) && (py + CH > ry);
    assign despawn[g] = act_q && (y_q >= DESPAWN_Y);

    // Only slots free before the tick reach the spawn branch.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        x_q   <= '0;
        y_q   <= '0;
        act_q <= 1'b0;
      end else if (tick) begin
        if (despawn[g]) begin
          act_q <= 1'b0;
        end else if (act_q) begin
          y_q <= y_q + Y_STEP_V;
        end else if (spawn_now && free_idx == 3'(g)) begin
          x_q   <= spawn_x;
          y_q   <= SPAWN_Y;
          act_q <= 1'b1;
        end
      end
    end

    assign rival_x[g*POS_W +: POS_W] = x_q;
    assign rival_y[g*POS_W +: POS_W] = y_q;
    assign rival_active[g]           = act_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt   <= '0;
      spawn_cnt   <= GAP_V;
      score       <= '0;
      level       <= '0;
      collision   <= 1'b0;
      collide_idx <= '0;
    end else begin
      if (frame_end && run && !collision)
        frame_cnt <= tick ? '0 : frame_cnt + FC_W'(1);
      if (tick) begin
        score <= score_next;
        level <= level_next;
        if (spawn_cnt >= GAP_V) begin
          if (free_found)
            spawn_cnt <= '0;
        end else begin
          spawn_cnt <= spawn_cnt + SC_W'(1);
        end
      end
      if (!collision && run && hit) begin
        collision   <= 1'b1;
        collide_idx <= hit_idx;
      end
    end
  end

endmodule

// File: tb/tb_rival_traffic_ctrl.sv
// Randomised scoreboard bench for rival_traffic_ctrl against a behavioural
// model of the slot rules.
module tb_rival_traffic_ctrl;

  localparam int N     = 3;
  localparam int PW    = 10;
  localparam int STEP  = 6;
  localparam int MINS  = 3;
  localparam int LSC   = 2;
  localparam int YS    = 8;
  localparam int GAP   = 4;
  localparam int SEED  = 8'hB5;
  localparam int X0    = 200 + 44;
  localparam int Y0    = 150;
  localparam int YDESP = 150 + 240;
  localparam int CW    = 14;
  localparam int CH    = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            frame_end;
  logic            run;
  logic [PW-1:0]   player_x;
  logic [PW-1:0]   player_y;
  logic [N*PW-1:0] rival_x;
  logic [N*PW-1:0] rival_y;
  logic [N-1:0]    rival_active;
  logic            collision;
  logic [2:0]      collide_idx;
  logic [15:0]     score;
  logic [3:0]      level;

  always #5 clk = ~clk;

  rival_traffic_ctrl #(
    .NUM_RIVALS(N), .POS_W(PW), .STEP_FRAMES(STEP), .MIN_STEP_FRAMES(MINS),
    .LEVEL_SCORE(LSC), .Y_STEP(YS), .SPAWN_GAP(GAP), .LFSR_SEED(8'hB5)
  ) dut (
    .clk(clk), .reset(reset), .frame_end(frame_end), .run(run),
    .player_x(player_x), .player_y(player_y),
    .rival_x(rival_x), .rival_y(rival_y), .rival_active(rival_active),
    .collision(collision), .collide_idx(collide_idx),
    .score(score), .level(level)
  );

  typedef struct {
    int              cyc;
    logic [N*PW-1:0] rx;
    logic [N*PW-1:0] ry;
    logic [N-1:0]    act;
    logic            coll;
    logic [2:0]      cidx;
    logic [15:0]     score;
    logic [3:0]      level;
  } snap_t;

  snap_t q[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  // Model state, always equal to what the DUT should hold after the last edge.
  int mx[N], my[N];
  bit ma[N];
  bit mc;
  int mci, mscore, mlvl, mfc, mspc, mlfsr;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic snap_t mk_snap(input int c);
    snap_t s;
    s.cyc = c;
    for (int i = 0; i < N; i++) begin
      s.rx[i*PW +: PW] = PW'(mx[i]);
      s.ry[i*PW +: PW] = PW'(my[i]);
      s.act[i]         = ma[i];
    end
    s.coll  = mc;
    s.cidx  = 3'(mci);
    s.score = 16'(mscore);
    s.level = 4'(mlvl);
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 0; my[i] = 0; ma[i] = 1'b0;
    end
    mc = 1'b0; mci = 0; mscore = 0; mlvl = 0; mfc = 0; mspc = GAP; mlfsr = SEED;
  endtask

  task automatic model_tick(input int lf);
    int free, old, cleared;
    free = -1;
    for (int i = 0; i < N; i++) if (!ma[i] && free < 0) free = i;
    old = mscore;
    cleared = 0;
    for (int i = 0; i < N; i++) begin
      if (ma[i]) begin
        if (my[i] >= YDESP) begin
          ma[i] = 1'b0;
          cleared++;
        end else begin
          my[i] += YS;
        end
      end
    end
    if (mspc >= GAP) begin
      if (free >= 0) begin
        mx[free] = X0 + ((lf * 60) >> 8);
        my[free] = Y0;
        ma[free] = 1'b1;
        mspc = 0;
      end
    end else begin
      mspc++;
    end
    mscore = (old + cleared > 65535) ? 65535 : old + cleared;
    mlvl   = mlvl + mscore / LSC - old / LSC;
    if (mlvl > 15) mlvl = 15;
  endtask

  task automatic model_cycle(input bit fe, input bit r, input int px, input int py);
    bit coll_pre;
    int lf_pre, period;
    coll_pre = mc;
    lf_pre   = mlfsr;
    if (!mc && r) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (ma[i] && px < mx[i] + CW && px + CW > mx[i] && py < my[i] + CH && py + CH > my[i]) begin
          mc  = 1'b1;
          mci = i;
        end
      end
    end
    if (fe)
      mlfsr = ((mlfsr << 1) & 8'hFF) | (((mlfsr >> 7) ^ (mlfsr >> 5) ^ (mlfsr >> 4) ^ (mlfsr >> 3)) & 1);
    if (fe && r && !coll_pre) begin
      period = (STEP - mlvl < MINS) ? MINS : STEP - mlvl;
      if (mfc == period - 1) begin
        mfc = 0;
        model_tick(lf_pre);
      end else begin
        mfc++;
      end
    end
  endtask

  task automatic step(input bit fe, input bit r, input int px, input int py);
    frame_end = fe;
    run       = r;
    player_x  = PW'(px);
    player_y  = PW'(py);
    model_cycle(fe, r, px, py);
    q.push_back(mk_snap(cyc + 1));
    @(posedge clk);
    #1;
  endtask

  // Reset is raised between edges, so outputs must already be clear at the
  // following negedge.
  task automatic reset_cycle();
    reset     = 1'b1;
    frame_end = 1'b0;
    run       = 1'b0;
    player_x  = '0;
    player_y  = '0;
    while (q.size() > 0 && q[$].cyc >= cyc) void'(q.pop_back());
    model_reset();
    q.push_back(mk_snap(cyc));
    q.push_back(mk_snap(cyc + 1));
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic random_frames(input int nframes);
    int gap;
    bit r;
    for (int f = 0; f < nframes; f++) begin
      gap = $urandom_range(2, 4);
      r   = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < gap; c++)
        step(c == 0, r, $urandom_range(0, 220), $urandom_range(0, 1000));
    end
  endtask

  initial begin : monitor
    snap_t s;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        s = q.pop_front();
        checks++;
        if (s.cyc != cyc || rival_x != s.rx || rival_y != s.ry || rival_active != s.act ||
            collision != s.coll || (s.coll && collide_idx != s.cidx) || (!s.coll && collide_idx != 3'd0) ||
            score != s.score || level != s.level) begin
          errors++;
          $display("FAIL state cyc=%0d(tag %0d): got x=%h y=%h act=%b coll=%b idx=%0d score=%0d lvl=%0d, expected x=%h y=%h act=%b coll=%b idx=%0d score=%0d lvl=%0d",
                   cyc, s.cyc, rival_x, rival_y, rival_active, collision, collide_idx, score, level,
                   s.rx, s.ry, s.act, s.coll, s.cidx, s.score, s.level);
        end
      end
    end
  end

  initial begin : watchdog
    #1_500_000;
    $display("FAIL timeout: bench did not complete, %0d checks, %0d errors so far", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin : driver
    int j, sc_at;
    reset     = 1'b1;
    frame_end = 1'b0;
    run       = 1'b0;
    player_x  = '0;
    player_y  = '0;
    @(posedge clk);
    #1;
    reset_cycle();
    reset_cycle();
    reset = 1'b0;

    // Long randomised run with the player parked left of the road.
    random_frames(4000);
    check_val("level_saturated", int'(level), 15);

    // Park the player on the lowest active rival.
    j = -1;
    for (int i = N - 1; i >= 0; i--) if (ma[i]) j = i;
    if (j < 0) begin
      errors++;
      checks++;
      $display("FAIL collision_setup: got no active slot, required at least one");
    end else begin
      sc_at = mscore;
      step(1'b0, 1'b1, mx[j] + 3, my[j] + 5);
      for (int f = 0; f < 30; f++) begin
        step(1'b1, 1'b1, int'(player_x), int'(player_y));
        step(1'b0, 1'b1, int'(player_x), int'(player_y));
        step(1'b0, 1'b1, int'(player_x), int'(player_y));
      end
      check_val("collision_sticky", int'(collision), 1);
      check_val("collide_idx", int'(collide_idx), j);
      check_val("score_frozen", int'(score), sc_at);
    end

    // Mid-frame asynchronous reset with slots in flight, then resume.
    step(1'b0, 1'b1, 0, 0);
    reset_cycle();
    reset_cycle();
    reset = 1'b0;
    check_val("post_reset_spawn_cnt_model", mspc, GAP);
    random_frames(400);

    step(1'b0, 1'b1, 0, 0);
    @(negedge clk);
    #1;
    check_val("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
